// File: rtl/pc_branch_redirect.sv
// Fetch PC register with branch/JAL redirect, stall buffering and flush.
// Optional MISALIGN_TRAP_EN: misaligned applied targets trap to TRAP_VEC.
module pc_branch_redirect #(
  parameter int unsigned    N        = 32,
  parameter logic [N-1:0]   RESET_PC = '0,
  parameter int unsigned    CNT_W    = 16,
  parameter logic [N-1:0]   TRAP_VEC = N'(4)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [N-1:0]     br_pc,
  input  logic [N-1:0]     br_imm,
  output logic [N-1:0]     pc,
  output logic [N-1:0]     pc_plus4,
  output logic             flush,
  output logic             redir_pend,
  output logic [CNT_W-1:0] redir_cnt,
  output logic             misalign_err
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } buf_state_e;

  buf_state_e   state;
  logic [N-1:0] pend_tgt;
  logic [N-1:0] tgt;
  logic [N-1:0] apply_tgt;
  logic [N-1:0] pc_nxt;
  logic         r;
  logic         rule_go;
  logic         rule_buf;
  logic         rule_drain;
  logic         rule_seq;
  logic         apply;
  logic         trap;
  logic         unused_imm_msb;

  // Offset is in halfwords, so its top bit falls off the byte shift.
  assign unused_imm_msb = br_imm[N-1];

  assign r          = br_valid & br_taken;
  assign tgt        = br_pc + {br_imm[N-2:0], 1'b0};
  assign rule_go    = r & ~stall;
  assign rule_buf   = r & stall;
  assign rule_drain = ~r & (state == PEND) & ~stall;
  assign rule_seq   = ~r & (state == IDLE) & ~stall;
  assign apply      = rule_go | rule_drain;
  assign apply_tgt  = rule_go ? tgt : pend_tgt;
  assign trap       = TRAP_EN & apply_tgt[1];
  assign redir_pend = (state == PEND);

  always_comb begin
    pc_nxt = pc;
    unique case (1'b1)
      apply:    pc_nxt = trap ? TRAP_VEC : apply_tgt;
      rule_seq: pc_nxt = pc + N'(4);
      default:  pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      pc_plus4     <= RESET_PC + N'(4);
      flush        <= 1'b0;
      misalign_err <= 1'b0;
      redir_cnt    <= '0;
      pend_tgt     <= '0;
      state        <= IDLE;
    end else begin
      pc           <= pc_nxt;
      pc_plus4     <= pc_nxt + N'(4);
      flush        <= apply;
      misalign_err <= apply & trap;
      if (r && (redir_cnt != {CNT_W{1'b1}}))
        redir_cnt <= redir_cnt + CNT_W'(1);
      unique case (state)
        IDLE: begin
          if (rule_buf) begin
            state    <= PEND;
            pend_tgt <= tgt;
          end
        end
        PEND: begin
          if (rule_buf)
            pend_tgt <= tgt;
          else if (apply)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_redirect.sv
// Scoreboard bench for pc_branch_redirect (plus a CNT_W=2 instance).
// Expectations follow MISALIGN_TRAP_EN when it is defined.
module tb_pc_branch_redirect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [31:0] br_imm;

  logic [31:0] pc, pc_plus4;
  logic        flush, redir_pend, misalign_err;
  logic [15:0] redir_cnt;

  logic [31:0] pc_b, pc_plus4_b;
  logic        flush_b, redir_pend_b, misalign_err_b;
  logic [1:0]  redir_cnt_b;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic        flush;
    logic        pend;
    logic [15:0] cnt;
    logic        merr;
  } exp_t;

  exp_t q[$];

  pc_branch_redirect dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .br_valid(br_valid), .br_taken(br_taken),
    .br_pc(br_pc), .br_imm(br_imm),
    .pc(pc), .pc_plus4(pc_plus4), .flush(flush),
    .redir_pend(redir_pend), .redir_cnt(redir_cnt),
    .misalign_err(misalign_err)
  );

  pc_branch_redirect #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .br_valid(br_valid), .br_taken(br_taken),
    .br_pc(br_pc), .br_imm(br_imm),
    .pc(pc_b), .pc_plus4(pc_plus4_b), .flush(flush_b),
    .redir_pend(redir_pend_b), .redir_cnt(redir_cnt_b),
    .misalign_err(misalign_err_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%08h want=0x%08h",
               name, cyc, act, exp);
    end
  endfunction

  function automatic void check_all(exp_t e);
    logic [1:0] c2;
    c2 = (e.cnt > 16'd3) ? 2'd3 : e.cnt[1:0];
    check("pc", pc, e.pc);
    check("pc_plus4", pc_plus4, e.pc + 32'd4);
    check("flush", {31'b0, flush}, {31'b0, e.flush});
    check("redir_pend", {31'b0, redir_pend}, {31'b0, e.pend});
    check("redir_cnt", {16'b0, redir_cnt}, {16'b0, e.cnt});
    check("misalign_err", {31'b0, misalign_err}, {31'b0, e.merr});
    check("b_pc", pc_b, e.pc);
    check("b_redir_cnt", {30'b0, redir_cnt_b}, {30'b0, c2});
  endfunction

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc != cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL stale_entry got_cyc=%0d want_cyc=%0d", cyc, e.cyc);
      end else begin
        check_all(e);
      end
    end
  end

  // Drive one cycle of inputs; queue the state expected after the edge.
  task automatic step(input logic st, input logic bv, input logic bt,
                      input logic [31:0] bpc, input logic [31:0] bimm,
                      input logic [31:0] e_pc, input logic e_flush,
                      input logic e_pend, input logic [15:0] e_cnt,
                      input logic e_merr);
    exp_t e;
    stall    = st;
    br_valid = bv;
    br_taken = bt;
    br_pc    = bpc;
    br_imm   = bimm;
    e.cyc    = cyc + 1;
    e.pc     = e_pc;
    e.flush  = e_flush;
    e.pend   = e_pend;
    e.cnt    = e_cnt;
    e.merr   = e_merr;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] e_pc, input logic [15:0] e_cnt);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, e_pc, 1'b0, 1'b0, e_cnt, 1'b0);
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_pc_plus4"}, pc_plus4, 32'h4);
    check({tag, "_flush"}, {31'b0, flush}, 32'h0);
    check({tag, "_pend"}, {31'b0, redir_pend}, 32'h0);
    check({tag, "_cnt"}, {16'b0, redir_cnt}, 32'h0);
    check({tag, "_merr"}, {31'b0, misalign_err}, 32'h0);
    check({tag, "_b_cnt"}, {30'b0, redir_cnt_b}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] trap_pc;
    logic        trap_e;
`ifdef MISALIGN_TRAP_EN
    trap_pc = 32'h4;
    trap_e  = 1'b1;
`else
    trap_pc = 32'h102;
    trap_e  = 1'b0;
`endif
    rst_n = 1'b0; stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
    br_pc = '0; br_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst_n = 1'b1;

    // Sequential fetch up to 0x38
    for (int i = 1; i <= 14; i++) idle(32'(4 * i), 16'd0);

    // Stalled redirect buffered, then async reset discards it
    step(1'b1, 1'b1, 1'b1, 32'h500, 32'h0, 32'h38, 1'b0, 1'b1, 16'd1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(32'h4, 16'd0);
    idle(32'h8, 16'd0);

    // Forward branch 0x100 + 0x10*2
    step(1'b0, 1'b1, 1'b1, 32'h100, 32'h10, 32'h120, 1'b1, 1'b0, 16'd1, 1'b0);
    idle(32'h124, 16'd1);

    // Backward branch, then a target that wraps past 2^32
    step(1'b0, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFF8, 32'h30, 1'b1, 1'b0, 16'd2, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h6, 32'hFFFF_FFFC, 1'b1, 1'b0, 16'd3, 1'b0);
    idle(32'h0, 16'd3);
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h10, 32'h10, 1'b1, 1'b0, 16'd4, 1'b0);

    // Two stalled redirects: the later one wins on release
    step(1'b1, 1'b1, 1'b1, 32'h200, 32'h0, 32'h10, 1'b0, 1'b1, 16'd5, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h300, 32'h0, 32'h10, 1'b0, 1'b1, 16'd6, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h10, 1'b0, 1'b1, 16'd6, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h300, 1'b1, 1'b0, 16'd6, 1'b0);
    idle(32'h304, 16'd6);

    // Unstalled redirect supersedes a pending one
    step(1'b1, 1'b1, 1'b1, 32'h400, 32'h0, 32'h304, 1'b0, 1'b1, 16'd7, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h600, 32'h0, 32'h600, 1'b1, 1'b0, 16'd8, 1'b0);

    // Not-taken branch behaves as sequential fetch
    step(1'b0, 1'b1, 1'b0, 32'h800, 32'h40, 32'h604, 1'b0, 1'b0, 16'd8, 1'b0);

    // Misaligned target, direct and via the pending buffer
    step(1'b0, 1'b1, 1'b1, 32'h100, 32'h1, trap_pc, 1'b1, 1'b0, 16'd9, trap_e);
    idle(trap_pc + 32'd4, 16'd9);
    step(1'b1, 1'b1, 1'b1, 32'h100, 32'h1, trap_pc + 32'd4, 1'b0, 1'b1, 16'd10, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, trap_pc, 1'b1, 1'b0, 16'd10, trap_e);
    idle(trap_pc + 32'd4, 16'd10);

    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain left=%0d want=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
